// File: rtl/inst_sram_port_arbiter.sv
// rtl/inst_sram_port_arbiter.sv - two-requester OBI arbiter for the instruction SRAM port
//
// Purpose: shares one OBI memory port between the core fetch unit (port 0) and an
// AXI adapter (port 1). Port 0 has priority. Port 1 takes over once it has waited
// STARVE_LIMIT cycles. A request that the memory stalls is locked until it is
// granted. A FIFO of port IDs sends each response back to the port that issued it.
//
// Ports:
//   clk_i, reset_i         clock, synchronous active-high reset
//   p0_* / p1_*            requester OBI ports (req/gnt/addr/we/be/wdata, rvalid/rdata)
//   mem_*                  memory-side OBI port
//   busy_o, outstanding_o  outstanding-transaction status
//   err_o                  sticky flag: response arrived with nothing outstanding
module inst_sram_port_arbiter #(
   parameter int ADDR_WIDTH      = 32,
   parameter int DATA_WIDTH      = 32,
   parameter int MAX_OUTSTANDING = 2,
   parameter int STARVE_LIMIT    = 8
) (
   input  logic                                 clk_i,
   input  logic                                 reset_i,
   input  logic                                 p0_req_i,
   output logic                                 p0_gnt_o,
   input  logic [ADDR_WIDTH-1:0]                p0_addr_i,
   input  logic                                 p0_we_i,
   input  logic [DATA_WIDTH/8-1:0]              p0_be_i,
   input  logic [DATA_WIDTH-1:0]                p0_wdata_i,
   output logic                                 p0_rvalid_o,
   output logic [DATA_WIDTH-1:0]                p0_rdata_o,
   input  logic                                 p1_req_i,
   output logic                                 p1_gnt_o,
   input  logic [ADDR_WIDTH-1:0]                p1_addr_i,
   input  logic                                 p1_we_i,
   input  logic [DATA_WIDTH/8-1:0]              p1_be_i,
   input  logic [DATA_WIDTH-1:0]                p1_wdata_i,
   output logic                                 p1_rvalid_o,
   output logic [DATA_WIDTH-1:0]                p1_rdata_o,
   output logic                                 mem_req_o,
   input  logic                                 mem_gnt_i,
   output logic [ADDR_WIDTH-1:0]                mem_addr_o,
   output logic                                 mem_we_o,
   output logic [DATA_WIDTH/8-1:0]              mem_be_o,
   output logic [DATA_WIDTH-1:0]                mem_wdata_o,
   input  logic                                 mem_rvalid_i,
   input  logic [DATA_WIDTH-1:0]                mem_rdata_i,
   output logic                                 busy_o,
   output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
   output logic                                 err_o
);

   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

   logic [MAX_OUTSTANDING-1:0] fifo_q;
   logic [PTR_W-1:0]           wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]           count_q;
   logic [SC_W-1:0]            starve_cnt_q;
   logic                       lock_q, lock_port_q;
   logic                       err_q;

   logic fifo_full, fifo_empty;
   logic sel_valid, sel_port;
   logic push, pop, head_port;

   // Selection. A locked request is replayed unconditionally. Otherwise, when the
   // FIFO is full nothing is issued, even if a pop happens in the same cycle.
   always_comb begin
      fifo_full  = (count_q == CNT_W'(MAX_OUTSTANDING));
      fifo_empty = (count_q == '0);
      sel_valid  = 1'b0;
      sel_port   = 1'b0;
      if (lock_q) begin
         sel_valid = 1'b1;
         sel_port  = lock_port_q;
      end else if (!fifo_full) begin
         if (p1_req_i && ((starve_cnt_q == SC_W'(STARVE_LIMIT)) || !p0_req_i)) begin
            sel_valid = 1'b1;
            sel_port  = 1'b1;
         end else if (p0_req_i) begin
            sel_valid = 1'b1;
         end
      end
   end

   assign push      = sel_valid && mem_gnt_i;
   assign pop       = mem_rvalid_i && !fifo_empty;
   assign head_port = fifo_q[rd_ptr_q];

   assign mem_req_o   = sel_valid;
   assign mem_addr_o  = !sel_valid ? '0   : (sel_port ? p1_addr_i  : p0_addr_i);
   assign mem_we_o    = !sel_valid ? 1'b0 : (sel_port ? p1_we_i    : p0_we_i);
   assign mem_be_o    = !sel_valid ? '0   : (sel_port ? p1_be_i    : p0_be_i);
   assign mem_wdata_o = !sel_valid ? '0   : (sel_port ? p1_wdata_i : p0_wdata_i);
   assign p0_gnt_o    = sel_valid && !sel_port && mem_gnt_i;
   assign p1_gnt_o    = sel_valid &&  sel_port && mem_gnt_i;

   assign p0_rvalid_o = pop && !head_port;
   assign p1_rvalid_o = pop &&  head_port;
   assign p0_rdata_o  = mem_rdata_i;
   assign p1_rdata_o  = mem_rdata_i;

   assign outstanding_o = count_q;
   assign busy_o        = (count_q != '0);
   assign err_o         = err_q;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         fifo_q       <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         starve_cnt_q <= '0;
         lock_q       <= 1'b0;
         lock_port_q  <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         if (push) begin
            fifo_q[wr_ptr_q] <= sel_port;
            wr_ptr_q <= (wr_ptr_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= (rd_ptr_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr_q + 1'b1;
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase

         if (!p1_req_i || (push && sel_port)) begin
            starve_cnt_q <= '0;
         end else if (starve_cnt_q != SC_W'(STARVE_LIMIT)) begin
            starve_cnt_q <= starve_cnt_q + SC_W'(1);
         end

         // Hold a stalled request so the memory sees stable fields until it grants.
         lock_q      <= sel_valid && !mem_gnt_i;
         lock_port_q <= sel_port;

         if (mem_rvalid_i && fifo_empty) begin
            err_q <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_inst_sram_port_arbiter.sv
// tb/tb_inst_sram_port_arbiter.sv - directed vector bench for inst_sram_port_arbiter
module tb_inst_sram_port_arbiter;

   localparam logic [31:0] P0_ADDR  = 32'h0000_0100;
   localparam logic [31:0] P1_ADDR  = 32'h0000_0200;
   localparam logic [31:0] P0_WDATA = 32'hA0A0_A0A0;
   localparam logic [31:0] P1_WDATA = 32'hB1B1_B1B1;
   localparam logic [3:0]  P0_BE    = 4'hF;
   localparam logic [3:0]  P1_BE    = 4'h3;

   logic        clk_i = 1'b0;
   logic        reset_i;
   logic        p0_req_i, p0_gnt_o, p0_we_i, p0_rvalid_o;
   logic [31:0] p0_addr_i, p0_wdata_i, p0_rdata_o;
   logic [3:0]  p0_be_i;
   logic        p1_req_i, p1_gnt_o, p1_we_i, p1_rvalid_o;
   logic [31:0] p1_addr_i, p1_wdata_i, p1_rdata_o;
   logic [3:0]  p1_be_i;
   logic        mem_req_o, mem_gnt_i, mem_we_o, mem_rvalid_i;
   logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
   logic [3:0]  mem_be_o;
   logic        busy_o, err_o;
   logic [1:0]  outstanding_o;

   int total = 0;
   int bad   = 0;

   inst_sram_port_arbiter dut (
      .clk_i(clk_i), .reset_i(reset_i),
      .p0_req_i(p0_req_i), .p0_gnt_o(p0_gnt_o), .p0_addr_i(p0_addr_i), .p0_we_i(p0_we_i),
      .p0_be_i(p0_be_i), .p0_wdata_i(p0_wdata_i), .p0_rvalid_o(p0_rvalid_o), .p0_rdata_o(p0_rdata_o),
      .p1_req_i(p1_req_i), .p1_gnt_o(p1_gnt_o), .p1_addr_i(p1_addr_i), .p1_we_i(p1_we_i),
      .p1_be_i(p1_be_i), .p1_wdata_i(p1_wdata_i), .p1_rvalid_o(p1_rvalid_o), .p1_rdata_o(p1_rdata_o),
      .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
      .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
      .busy_o(busy_o), .outstanding_o(outstanding_o), .err_o(err_o)
   );

   always #5 clk_i = ~clk_i;

   // sel: 0 none, 1 port 0, 2 port 1
   typedef struct packed {
      logic        p0r, p1r, gnt, rv;
      logic [31:0] rdata;
      logic [1:0]  sel;
      logic        g0, g1, rv0, rv1;
      logic [1:0]  outst;
      logic        err;
   } vec_t;

   vec_t vt [15];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic drive(input logic p0r, input logic p1r, input logic gnt, input logic rv,
                        input logic [31:0] rdata);
      @(negedge clk_i);
      p0_req_i = p0r; p1_req_i = p1r; mem_gnt_i = gnt; mem_rvalid_i = rv; mem_rdata_i = rdata;
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk_i);
      p0_req_i = 0; p1_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0;
      reset_i = 1'b1;
      @(negedge clk_i);
      @(negedge clk_i);
      reset_i = 1'b0;
   endtask

   initial begin
      logic [31:0] e_addr, e_wdata;
      logic [3:0]  e_be;
      logic        e_we;

      reset_i = 1'b1;
      p0_req_i = 0; p1_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0;
      p0_addr_i = P0_ADDR; p0_we_i = 1'b0; p0_be_i = P0_BE; p0_wdata_i = P0_WDATA;
      p1_addr_i = P1_ADDR; p1_we_i = 1'b1; p1_be_i = P1_BE; p1_wdata_i = P1_WDATA;

      //           p0r p1r gnt rv  rdata          sel   g0 g1 rv0 rv1 out   err
      vt[0]  = '{1'b0,1'b0,1'b0,1'b0,32'h0,        2'd0,1'b0,1'b0,1'b0,1'b0,2'd0,1'b0};
      vt[1]  = '{1'b1,1'b0,1'b1,1'b0,32'h0,        2'd1,1'b1,1'b0,1'b0,1'b0,2'd0,1'b0};
      vt[2]  = '{1'b0,1'b0,1'b0,1'b1,32'hDEADBEEF, 2'd0,1'b0,1'b0,1'b1,1'b0,2'd1,1'b0};
      vt[3]  = '{1'b0,1'b0,1'b0,1'b0,32'h0,        2'd0,1'b0,1'b0,1'b0,1'b0,2'd0,1'b0};
      vt[4]  = '{1'b0,1'b1,1'b0,1'b0,32'h0,        2'd2,1'b0,1'b0,1'b0,1'b0,2'd0,1'b0};
      vt[5]  = '{1'b1,1'b1,1'b0,1'b0,32'h0,        2'd2,1'b0,1'b0,1'b0,1'b0,2'd0,1'b0};
      vt[6]  = '{1'b1,1'b1,1'b0,1'b0,32'h0,        2'd2,1'b0,1'b0,1'b0,1'b0,2'd0,1'b0};
      vt[7]  = '{1'b1,1'b1,1'b1,1'b0,32'h0,        2'd2,1'b0,1'b1,1'b0,1'b0,2'd0,1'b0};
      vt[8]  = '{1'b1,1'b0,1'b1,1'b1,32'h11,       2'd1,1'b1,1'b0,1'b0,1'b1,2'd1,1'b0};
      vt[9]  = '{1'b0,1'b1,1'b1,1'b0,32'h0,        2'd2,1'b0,1'b1,1'b0,1'b0,2'd1,1'b0};
      vt[10] = '{1'b1,1'b0,1'b1,1'b0,32'h0,        2'd0,1'b0,1'b0,1'b0,1'b0,2'd2,1'b0};
      vt[11] = '{1'b1,1'b0,1'b1,1'b1,32'h22,       2'd0,1'b0,1'b0,1'b1,1'b0,2'd2,1'b0};
      vt[12] = '{1'b0,1'b0,1'b0,1'b1,32'h33,       2'd0,1'b0,1'b0,1'b0,1'b1,2'd1,1'b0};
      vt[13] = '{1'b0,1'b0,1'b0,1'b1,32'h44,       2'd0,1'b0,1'b0,1'b0,1'b0,2'd0,1'b0};
      vt[14] = '{1'b0,1'b0,1'b0,1'b0,32'h0,        2'd0,1'b0,1'b0,1'b0,1'b0,2'd0,1'b1};

      do_reset();

      for (int i = 0; i < 15; i++) begin
         drive(vt[i].p0r, vt[i].p1r, vt[i].gnt, vt[i].rv, vt[i].rdata);
         e_addr  = (vt[i].sel == 2'd1) ? P0_ADDR  : (vt[i].sel == 2'd2) ? P1_ADDR  : 32'h0;
         e_wdata = (vt[i].sel == 2'd1) ? P0_WDATA : (vt[i].sel == 2'd2) ? P1_WDATA : 32'h0;
         e_be    = (vt[i].sel == 2'd1) ? P0_BE    : (vt[i].sel == 2'd2) ? P1_BE    : 4'h0;
         e_we    = (vt[i].sel == 2'd2);
         chk($sformatf("v%0d mem_req", i), {31'b0, mem_req_o}, {31'b0, vt[i].sel != 2'd0});
         chk($sformatf("v%0d mem_addr", i), mem_addr_o, e_addr);
         chk($sformatf("v%0d mem_we", i), {31'b0, mem_we_o}, {31'b0, e_we});
         chk($sformatf("v%0d mem_be", i), {28'b0, mem_be_o}, {28'b0, e_be});
         chk($sformatf("v%0d mem_wdata", i), mem_wdata_o, e_wdata);
         chk($sformatf("v%0d p0_gnt", i), {31'b0, p0_gnt_o}, {31'b0, vt[i].g0});
         chk($sformatf("v%0d p1_gnt", i), {31'b0, p1_gnt_o}, {31'b0, vt[i].g1});
         chk($sformatf("v%0d p0_rvalid", i), {31'b0, p0_rvalid_o}, {31'b0, vt[i].rv0});
         chk($sformatf("v%0d p1_rvalid", i), {31'b0, p1_rvalid_o}, {31'b0, vt[i].rv1});
         if (vt[i].rv0) chk($sformatf("v%0d p0_rdata", i), p0_rdata_o, vt[i].rdata);
         if (vt[i].rv1) chk($sformatf("v%0d p1_rdata", i), p1_rdata_o, vt[i].rdata);
         chk($sformatf("v%0d outstanding", i), {30'b0, outstanding_o}, {30'b0, vt[i].outst});
         chk($sformatf("v%0d busy", i), {31'b0, busy_o}, {31'b0, vt[i].outst != 2'd0});
         chk($sformatf("v%0d err", i), {31'b0, err_o}, {31'b0, vt[i].err});
      end

      // err_o is sticky until reset
      do_reset();
      drive(0, 0, 0, 0, 32'h0);
      chk("err_cleared", {31'b0, err_o}, 32'h0);
      chk("reset_outstanding", {30'b0, outstanding_o}, 32'h0);

      // starvation flip: both request, memory grants every cycle and answers the next
      for (int c = 1; c <= 10; c++) begin
         drive(1, 1, 1, c > 1, 32'(c));
         chk($sformatf("starve c%0d p0_gnt", c), {31'b0, p0_gnt_o}, {31'b0, c != 9});
         chk($sformatf("starve c%0d p1_gnt", c), {31'b0, p1_gnt_o}, {31'b0, c == 9});
         chk($sformatf("starve c%0d p0_rvalid", c), {31'b0, p0_rvalid_o}, {31'b0, c > 1 && c != 10});
         chk($sformatf("starve c%0d p1_rvalid", c), {31'b0, p1_rvalid_o}, {31'b0, c == 10});
         chk($sformatf("starve c%0d outstanding", c), {30'b0, outstanding_o}, {30'b0, c > 1 ? 2'd1 : 2'd0});
      end
      drive(0, 0, 0, 1, 32'h55);
      chk("starve drain p0_rvalid", {31'b0, p0_rvalid_o}, 32'h1);
      chk("starve drain p0_rdata", p0_rdata_o, 32'h55);
      drive(0, 0, 0, 0, 32'h0);
      chk("starve drained", {30'b0, outstanding_o}, 32'h0);

      // reset with a transaction outstanding discards it; its late response is unexpected
      drive(1, 0, 1, 0, 32'h0);
      chk("midreset p0_gnt", {31'b0, p0_gnt_o}, 32'h1);
      do_reset();
      drive(0, 0, 0, 0, 32'h0);
      chk("midreset outstanding", {30'b0, outstanding_o}, 32'h0);
      chk("midreset busy", {31'b0, busy_o}, 32'h0);
      drive(0, 0, 0, 1, 32'h66);
      chk("midreset late p0_rvalid", {31'b0, p0_rvalid_o}, 32'h0);
      drive(0, 0, 0, 0, 32'h0);
      chk("midreset late err", {31'b0, err_o}, 32'h1);
      chk("midreset late outstanding", {30'b0, outstanding_o}, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
